// File: rtl/frame_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_read_arbiter
// Description : Shares the frame-buffer read port between VGA scan-out and
//               photo save. Grants one whole-frame session at a time,
//               forwards the req/ack handshake, muxes the read strobe,
//               and publishes a frame lock for the frame being saved.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_read_arbiter #(
    parameter int          STARVE_MAX     = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215,
    parameter int          IDX_W          = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vga_read_req,
    output logic             vga_read_req_ack,
    input  logic             vga_read_en,
    output logic [15:0]      vga_read_data,
    input  logic             save_read_req,
    output logic             save_read_req_ack,
    input  logic             save_read_en,
    output logic [15:0]      save_read_data,
    input  logic             save_done,
    input  logic [IDX_W-1:0] cmos_read_addr_index,
    output logic             read_req,
    input  logic             read_req_ack,
    input  logic             read_finish,
    output logic [IDX_W-1:0] read_addr_index,
    output logic             read_en,
    input  logic [15:0]      read_data,
    output logic             lock_valid,
    output logic [IDX_W-1:0] lock_index,
    output logic [1:0]       owner,
    output logic             timeout_err
);

    localparam int c_SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_BUSY = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_VGA  = 2'd1;
    localparam logic [1:0] c_OWN_SAVE = 2'd2;

    logic [1:0]      r_state;
    logic [c_SW-1:0] r_starve;
    logic [23:0]     r_tcnt;

    logic w_grant_save;
    logic w_grant_vga;

    // Save wins when VGA is idle or once VGA has starved it STARVE_MAX times.
    assign w_grant_save = save_read_req && (!vga_read_req || (r_starve == c_STARVE_MAX));
    assign w_grant_vga  = vga_read_req && !w_grant_save;

    // Read data is shared; only the session owner gives it meaning.
    assign vga_read_data  = read_data;
    assign save_read_data = read_data;

    // Route the owner's read strobe to the engine during a session only.
    always_comb begin
        read_en = 1'b0;
        if (r_state == c_ST_BUSY) begin
            if (owner == c_OWN_VGA) begin
                read_en = vga_read_en;
            end else if (owner == c_OWN_SAVE) begin
                read_en = save_read_en;
            end
        end
    end

    // Session state machine: arbitration, handshake, timeout and frame lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= c_ST_IDLE;
            r_starve          <= '0;
            r_tcnt            <= '0;
            vga_read_req_ack  <= 1'b0;
            save_read_req_ack <= 1'b0;
            read_req          <= 1'b0;
            read_addr_index   <= '0;
            lock_valid        <= 1'b0;
            lock_index        <= '0;
            owner             <= c_OWN_NONE;
            timeout_err       <= 1'b0;
        end else begin
            vga_read_req_ack  <= 1'b0;
            save_read_req_ack <= 1'b0;

            // A save grant below overrides this release in the same cycle.
            if (save_done && lock_valid) begin
                lock_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_save) begin
                        owner           <= c_OWN_SAVE;
                        read_addr_index <= cmos_read_addr_index;
                        lock_valid      <= 1'b1;
                        lock_index      <= cmos_read_addr_index;
                        r_starve        <= '0;
                        read_req        <= 1'b1;
                        r_state         <= c_ST_REQ;
                    end else if (w_grant_vga) begin
                        owner           <= c_OWN_VGA;
                        read_addr_index <= cmos_read_addr_index;
                        read_req        <= 1'b1;
                        r_state         <= c_ST_REQ;
                        if (!save_read_req) begin
                            r_starve <= '0;
                        end else if (r_starve != c_STARVE_MAX) begin
                            r_starve <= r_starve + c_SW'(1);
                        end
                    end
                end
                c_ST_REQ: begin
                    if (read_req_ack) begin
                        read_req <= 1'b0;
                        if (owner == c_OWN_VGA) begin
                            vga_read_req_ack <= 1'b1;
                        end else begin
                            save_read_req_ack <= 1'b1;
                        end
                        r_tcnt  <= '0;
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (read_finish) begin
                        owner   <= c_OWN_NONE;
                        r_tcnt  <= '0;
                        r_state <= c_ST_GAP;
                    end else if (r_tcnt == TIMEOUT_CYCLES - 24'd1) begin
                        timeout_err <= 1'b1;
                        owner       <= c_OWN_NONE;
                        if (owner == c_OWN_SAVE) begin
                            lock_valid <= 1'b0;
                        end
                        r_tcnt  <= '0;
                        r_state <= c_ST_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + 24'd1;
                    end
                end
                c_ST_GAP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
